// File: rtl/isp_cfg_pkg.sv
// Shared definitions for the ISP configuration controller: register map,
// display-mode and gamma encodings, and the dwell helper.
package isp_cfg_pkg;

  // Host register addresses
  localparam logic [1:0] ADDR_MODE  = 2'd0;
  localparam logic [1:0] ADDR_GAMMA = 2'd1;
  localparam logic [1:0] ADDR_AUTO  = 2'd2;
  localparam logic [1:0] ADDR_DWELL = 2'd3;

  // Pipeline stage taps selectable on the display mux (8..15 = debug pattern)
  typedef enum logic [3:0] {
    RAW = 4'd0,
    DPC = 4'd1,
    BNR = 4'd2,
    CFA = 4'd3,
    AWB = 4'd4,
    CCM = 4'd5,
    GMA = 4'd6,
    ENH = 4'd7
  } disp_mode_e;

  // Gamma curve selection
  typedef enum logic [1:0] {
    GAMMA_LIN    = 2'd0,
    GAMMA_SRGB   = 2'd1,
    GAMMA_22     = 2'd2,
    GAMMA_CUSTOM = 2'd3
  } gamma_e;

  // A dwell of zero frames would never advance, so it behaves as one frame.
  function automatic logic [7:0] dwell_eff(input logic [7:0] dwell);
    return (dwell == 8'd0) ? 8'd1 : dwell;
  endfunction

endpackage

// File: rtl/isp_auto_seq.sv
// Auto-cycle sequencer: counts committed frames per mode and steps the
// display-mode index 0..AUTO_LAST. Only moves on a commit strobe.
module isp_auto_seq
  import isp_cfg_pkg::*;
#(
  parameter int AUTO_LAST = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       commit,
  input  logic       auto_en,
  input  logic       auto_active,
  input  logic [7:0] dwell,
  output logic [3:0] idx_nxt
);

  localparam logic [3:0] LAST_C = 4'(AUTO_LAST);

  logic [7:0] cnt_r;
  logic [3:0] idx_r;
  logic [7:0] cnt_nxt_s;
  logic [3:0] idx_nxt_s;

  // Next dwell count and index as they would be after a commit this cycle
  always_comb begin
    cnt_nxt_s = cnt_r;
    idx_nxt_s = idx_r;
    if (!auto_en) begin
      cnt_nxt_s = 8'd0;
      idx_nxt_s = 4'd0;
    end else if (!auto_active) begin
      // entering auto restarts the sequence from RAW
      cnt_nxt_s = 8'd0;
      idx_nxt_s = 4'd0;
    end else if (cnt_r == (dwell_eff(dwell) - 8'd1)) begin
      cnt_nxt_s = 8'd0;
      idx_nxt_s = (idx_r == LAST_C) ? 4'd0 : (idx_r + 4'd1);
    end else begin
      cnt_nxt_s = cnt_r + 8'd1;
      idx_nxt_s = idx_r;
    end
  end

  // Sequencer state only advances on a frame commit
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= 8'd0;
      idx_r <= 4'd0;
    end else if (commit) begin
      cnt_r <= cnt_nxt_s;
      idx_r <= idx_nxt_s;
    end else begin
      cnt_r <= cnt_r;
      idx_r <= idx_r;
    end
  end

  assign idx_nxt = idx_nxt_s;

endmodule

// File: rtl/isp_cfg_ctrl.sv
// Frame-synchronous configuration controller: host writes land in shadow
// registers and are committed to the ISP controls on each vsync rising edge.
module isp_cfg_ctrl
  import isp_cfg_pkg::*;
#(
  parameter int AUTO_LAST = 7,
  parameter int DWELL_RST = 30,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_vsync,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [3:0]        isp_disp_mode,
  output logic [1:0]        gamma_type,
  output logic              auto_active,
  output logic              cfg_pending,
  output logic              commit_pulse,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic              vs_d_r;
  logic              edge_s;
  logic              wr_fire_s;
  logic [3:0]        sh_mode_r;
  logic [1:0]        sh_gamma_r;
  logic              sh_auto_r;
  logic [7:0]        sh_dwell_r;
  logic [3:0]        act_mode_r;
  logic [1:0]        act_gamma_r;
  logic              act_auto_r;
  logic              pend_r;
  logic              pend_s;
  logic              commit_r;
  logic [FCNT_W-1:0] fcnt_r;
  logic [3:0]        auto_idx_s;

  // Writes are held off in the commit cycle so they always target the next frame
  assign edge_s    = in_vsync & ~vs_d_r;
  assign wr_ready  = ~edge_s;
  assign wr_fire_s = wr_valid & wr_ready;

  isp_auto_seq #(
    .AUTO_LAST (AUTO_LAST)
  ) u_auto_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .commit      (edge_s),
    .auto_en     (sh_auto_r),
    .auto_active (act_auto_r),
    .dwell       (sh_dwell_r),
    .idx_nxt     (auto_idx_s)
  );

  // Shadow vs active comparison; mode is don't-care while auto drives it
  always_comb begin
    pend_s = 1'b0;
    if (sh_auto_r) begin
      pend_s = (sh_gamma_r != act_gamma_r) | (sh_auto_r != act_auto_r);
    end else begin
      pend_s = (sh_mode_r != act_mode_r) | (sh_gamma_r != act_gamma_r) |
               (sh_auto_r != act_auto_r);
    end
  end

  // Vsync edge history and host shadow register writes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vs_d_r     <= 1'b0;
      sh_mode_r  <= RAW;
      sh_gamma_r <= GAMMA_LIN;
      sh_auto_r  <= 1'b0;
      sh_dwell_r <= 8'(DWELL_RST);
    end else begin
      vs_d_r <= in_vsync;
      if (wr_fire_s) begin
        case (wr_addr)
          ADDR_MODE:  sh_mode_r  <= wr_data[3:0];
          ADDR_GAMMA: sh_gamma_r <= wr_data[1:0];
          ADDR_AUTO:  sh_auto_r  <= wr_data[0];
          ADDR_DWELL: sh_dwell_r <= wr_data;
          default:    sh_mode_r  <= sh_mode_r;
        endcase
      end else begin
        sh_mode_r <= sh_mode_r;
      end
    end
  end

  // Active settings, frame counter and status flags, committed at frame start
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_mode_r  <= RAW;
      act_gamma_r <= GAMMA_LIN;
      act_auto_r  <= 1'b0;
      fcnt_r      <= '0;
      commit_r    <= 1'b0;
      pend_r      <= 1'b0;
    end else begin
      commit_r <= edge_s;
      pend_r   <= pend_s;
      if (edge_s) begin
        act_gamma_r <= sh_gamma_r;
        act_auto_r  <= sh_auto_r;
        act_mode_r  <= sh_auto_r ? auto_idx_s : sh_mode_r;
        fcnt_r      <= fcnt_r + FCNT_W'(1'b1);
      end else begin
        act_mode_r <= act_mode_r;
      end
    end
  end

  assign isp_disp_mode = act_mode_r;
  assign gamma_type    = act_gamma_r;
  assign auto_active   = act_auto_r;
  assign cfg_pending   = pend_r;
  assign commit_pulse  = commit_r;
  assign frame_cnt     = fcnt_r;

endmodule

// File: tb/tb_isp_cfg_ctrl.sv
// Self-checking bench for isp_cfg_ctrl: directed frame scenarios followed by
// randomized traffic, every cycle compared against a frame-level model.
module tb_isp_cfg_ctrl;

  localparam int AUTO_LAST = 7;
  localparam int DWELL_RST = 30;
  localparam int FCNT_W    = 16;

  logic              clk;
  logic              reset_n;
  logic              in_vsync;
  logic              wr_valid;
  logic              wr_ready;
  logic [1:0]        wr_addr;
  logic [7:0]        wr_data;
  logic [3:0]        isp_disp_mode;
  logic [1:0]        gamma_type;
  logic              auto_active;
  logic              cfg_pending;
  logic              commit_pulse;
  logic [FCNT_W-1:0] frame_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int m_sh_mode, m_sh_gamma, m_sh_auto, m_sh_dwell;
  int m_mode, m_gamma, m_auto, m_pend, m_pulse, m_frames, m_vs_d;
  int m_dcnt, m_idx;

  isp_cfg_ctrl #(
    .AUTO_LAST (AUTO_LAST),
    .DWELL_RST (DWELL_RST),
    .FCNT_W    (FCNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_vsync      (in_vsync),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .isp_disp_mode (isp_disp_mode),
    .gamma_type    (gamma_type),
    .auto_active   (auto_active),
    .cfg_pending   (cfg_pending),
    .commit_pulse  (commit_pulse),
    .frame_cnt     (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the specified behaviour, applied at frame granularity
  task automatic model_step(input logic rst, input logic vs, input logic wv,
                            input logic [1:0] wa, input logic [7:0] wd);
    bit edge_b;
    bit np;
    int eff;
    if (!rst) begin
      m_sh_mode = 0; m_sh_gamma = 0; m_sh_auto = 0; m_sh_dwell = DWELL_RST;
      m_mode = 0; m_gamma = 0; m_auto = 0; m_pend = 0; m_pulse = 0;
      m_frames = 0; m_vs_d = 0; m_dcnt = 0; m_idx = 0;
    end else begin
      edge_b = vs && (m_vs_d == 0);
      np = (m_sh_gamma != m_gamma) || (m_sh_auto != m_auto) ||
           (m_sh_auto == 0 && m_sh_mode != m_mode);
      if (edge_b) begin
        m_frames = (m_frames + 1) % (1 << FCNT_W);
        if (m_sh_auto == 0) begin
          m_mode = m_sh_mode; m_dcnt = 0; m_idx = 0;
        end else if (m_auto == 0) begin
          m_mode = 0; m_dcnt = 0; m_idx = 0;
        end else begin
          eff = (m_sh_dwell == 0) ? 1 : m_sh_dwell;
          if (m_dcnt == eff - 1) begin
            m_dcnt = 0;
            m_idx  = (m_idx + 1) % (AUTO_LAST + 1);
            m_mode = m_idx;
          end else begin
            m_dcnt = (m_dcnt + 1) % 256;
          end
        end
        m_gamma = m_sh_gamma;
        m_auto  = m_sh_auto;
      end
      m_pulse = edge_b ? 1 : 0;
      if (wv && !edge_b) begin
        case (wa)
          2'd0: m_sh_mode  = wd % 16;
          2'd1: m_sh_gamma = wd % 4;
          2'd2: m_sh_auto  = wd % 2;
          default: m_sh_dwell = wd;
        endcase
      end
      m_vs_d = vs ? 1 : 0;
      m_pend = np ? 1 : 0;
    end
  endtask

  task automatic check_all();
    check_val("wr_ready", 32'(wr_ready), 32'((in_vsync && m_vs_d == 0) ? 0 : 1));
    check_val("isp_disp_mode", 32'(isp_disp_mode), 32'(m_mode));
    check_val("gamma_type", 32'(gamma_type), 32'(m_gamma));
    check_val("auto_active", 32'(auto_active), 32'(m_auto));
    check_val("cfg_pending", 32'(cfg_pending), 32'(m_pend));
    check_val("commit_pulse", 32'(commit_pulse), 32'(m_pulse));
    check_val("frame_cnt", 32'(frame_cnt), 32'(m_frames));
  endtask

  // Drive one clock: inputs after the edge, compare at negedge, then advance
  task automatic cycle(input logic rst, input logic vs, input logic wv,
                       input logic [1:0] wa, input logic [7:0] wd);
    reset_n = rst; in_vsync = vs; wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    check_all();
    model_step(rst, vs, wv, wa, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic vs);
    cycle(1'b1, vs, 1'b0, 2'd0, 8'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b0, 1'b1, a, d);
  endtask

  task automatic commit_frame();
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
  endtask

  int exp_seq[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
  int pulses;
  int lowleft;
  int highleft;

  initial begin
    reset_n = 1'b0; in_vsync = 1'b0; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
    model_step(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 8'd0);
    idle(1'b0);

    // first frame after reset commits reset values
    commit_frame();
    check_val("t1_pulse", 32'(commit_pulse), 32'd1);
    check_val("t1_fcnt", 32'(frame_cnt), 32'd1);
    check_val("t1_mode", 32'(isp_disp_mode), 32'd0);
    idle(1'b0);
    check_val("t1_pulse_end", 32'(commit_pulse), 32'd0);

    // mid-frame writes stay pending until the next edge
    wr(2'd0, 8'd5);
    wr(2'd1, 8'd2);
    idle(1'b0);
    check_val("t2_pend", 32'(cfg_pending), 32'd1);
    check_val("t2_mode_hold", 32'(isp_disp_mode), 32'd0);
    idle(1'b1);
    check_val("t2_mode", 32'(isp_disp_mode), 32'd5);
    check_val("t2_gamma", 32'(gamma_type), 32'd2);
    idle(1'b0);
    check_val("t2_pend_clr", 32'(cfg_pending), 32'd0);

    // write in the edge cycle is stalled and lands in the next frame
    idle(1'b0);
    in_vsync = 1'b1; wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 8'd3;
    #1;
    check_val("t3_stall", 32'(wr_ready), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'd3);
    check_val("t3_old_shadow", 32'(isp_disp_mode), 32'd5);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 8'd3);
    idle(1'b0);
    idle(1'b1);
    check_val("t3_new_mode", 32'(isp_disp_mode), 32'd3);

    // auto sequence with dwell 2
    wr(2'd3, 8'd2);
    wr(2'd2, 8'd1);
    for (int i = 0; i < 8; i++) begin
      commit_frame();
      check_val("t4_auto_seq", 32'(isp_disp_mode), 32'(exp_seq[i]));
    end
    wr(2'd2, 8'd0);
    commit_frame();
    check_val("t4_exit_mode", 32'(isp_disp_mode), 32'd3);

    // dwell 1 walks every mode then wraps
    wr(2'd3, 8'd1);
    wr(2'd2, 8'd1);
    commit_frame();
    check_val("t4_enter", 32'(isp_disp_mode), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      commit_frame();
      check_val("t4_wrap_seq", 32'(isp_disp_mode), 32'(i % 8));
    end

    // dwell 0 behaves as 1, then leave auto with an explicit mode
    wr(2'd3, 8'd0);
    for (int i = 1; i <= 2; i++) begin
      commit_frame();
      check_val("t5_dwell0", 32'(isp_disp_mode), 32'(i));
    end
    wr(2'd2, 8'd0);
    wr(2'd0, 8'd4);
    commit_frame();
    check_val("t5_mode", 32'(isp_disp_mode), 32'd4);
    check_val("t5_auto_off", 32'(auto_active), 32'd0);

    // mid-frame reset, then a long vsync high gives one commit
    wr(2'd0, 8'd6);
    commit_frame();
    check_val("t6_mode6", 32'(isp_disp_mode), 32'd6);
    idle(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
    check_val("t6_rst_mode", 32'(isp_disp_mode), 32'd0);
    check_val("t6_rst_fcnt", 32'(frame_cnt), 32'd0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      idle(1'b1);
      if (commit_pulse) pulses++;
    end
    check_val("t6_one_commit", 32'(pulses), 32'd1);
    check_val("t6_fcnt", 32'(frame_cnt), 32'd1);

    // randomized traffic against the model
    lowleft = 5;
    highleft = 0;
    for (int i = 0; i < 3000; i++) begin
      logic rst_b, vs_b, wv_b;
      logic [1:0] a_b;
      logic [7:0] d_b;
      if (highleft > 0) begin
        vs_b = 1'b1; highleft--;
        if (highleft == 0) lowleft = $urandom_range(3, 20);
      end else if (lowleft > 0) begin
        vs_b = 1'b0; lowleft--;
        if (lowleft == 0) highleft = $urandom_range(1, 3);
      end else begin
        vs_b = 1'b0; lowleft = 4;
      end
      rst_b = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      wv_b  = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      a_b   = 2'($urandom_range(0, 3));
      d_b   = (a_b == 2'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      cycle(rst_b, vs_b, wv_b, a_b, d_b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/isp_cfg_ctrl.md
Name: isp_cfg_ctrl

Overview:
Frame-synchronous configuration controller for the ISP pipeline top.
- Holds host-written shadow settings for display-mode select (stage tap) and gamma curve.
- Commits them to the active outputs only at a frame boundary (rising edge of in_vsync), so the output mux and gamma LUT never switch mid-frame.
- Provides an auto-cycle sequencer that steps the display mode through pipeline stages every N frames for bring-up/demo.
- Sits between the host/register bus and the isp_disp_mode / gamma_type inputs of the ISP top.

Parameters:
AUTO_LAST, 7, last display mode visited by the auto sequencer (sequence 0..AUTO_LAST, wraps).
DWELL_RST, 30, reset value of dwell register (frames per mode in auto).
FCNT_W, 16, width of frame counter.

Ports:
clk  in  1  pixel clock.
reset_n  in  1  synchronous active-low reset.
in_vsync  in  1  raw-input vsync, active high; frame boundary = 0→1 transition.
wr_valid  in  1  host write request.
wr_ready  out  1  write accepted when wr_valid&wr_ready.
wr_addr  in  2  register select.
wr_data  in  8  write data.
isp_disp_mode  out  4  active stage select.
gamma_type  out  2  active gamma curve.
auto_active  out  1  active auto-cycle enable.
cfg_pending  out  1  shadow differs from active.
commit_pulse  out  1  one-cycle pulse on each commit.
frame_cnt  out  FCNT_W  frames since reset, wraps.

Behaviour:
- One clock, clk. Reset is synchronous, active-low on reset_n. All state updates on posedge clk.
- Reset state:
  - shadow/active mode = 0, gamma = 0, auto_en = 0, dwell = DWELL_RST.
  - frame_cnt = 0, dwell counter = 0, auto index = 0, vs_d = 0.
  - commit_pulse = 0, cfg_pending = 0, wr_ready = 1 (combinational).
- Register map (write-only):
  - addr0: mode = wr_data[3:0].
  - addr1: gamma = wr_data[1:0].
  - addr2: auto_en = wr_data[0].
  - addr3: dwell = wr_data[7:0]; dwell 0 is treated as 1.
  - Unused data bits are ignored.
- Edge detect: vs_d <= in_vsync each cycle; edge = in_vsync & ~vs_d (combinational).
- wr_ready = ~edge. A write offered in the edge cycle is stalled one cycle and lands in the next frame's shadow. This removes write/commit races.
- Accepted write updates the shadow register at the clock edge ending the handshake cycle.
- Commit (cycle T with edge=1), registered at end of T, visible from T+1:
  - gamma_type <= shadow gamma; auto_active <= shadow auto_en.
  - commit_pulse <= 1 for exactly one cycle.
  - frame_cnt <= frame_cnt+1, wrapping at 2^FCNT_W.
  - If shadow auto_en=0: isp_disp_mode <= shadow mode; dwell counter and auto index <= 0.
  - If shadow auto_en=1 and auto_active was 0 (entering auto): isp_disp_mode <= 0; index <= 0; dwell counter <= 0.
  - If shadow auto_en=1 and auto_active was 1:
    - if dwell counter == max(dwell,1)-1, then counter <= 0, index <= (index==AUTO_LAST ? 0 : index+1), isp_disp_mode <= new index;
    - else counter <= counter+1 and mode holds.
- Before the first edge after reset, outputs hold reset values (RAW mode, gamma 0).
- cfg_pending:
  - with auto_en=0 in shadow: (shadow mode ≠ active mode) | (shadow gamma ≠ active gamma) | (shadow auto_en ≠ auto_active);
  - with auto_en=1 in shadow: mode is excluded from the compare.
  - Registered; updates the cycle after any shadow/active change.
- Mode values 8..15 pass through unchanged (downstream shows the debug pattern).
- in_vsync held high spans produce a single commit; no commit while low.
- Reset asserted mid-frame: everything returns to reset state at the next clock; the next 0→1 edge commits normally.

Decomposition:
- Shared package isp_cfg_pkg:
  - register address constants (ADDR_MODE=0, ADDR_GAMMA=1, ADDR_AUTO=2, ADDR_DWELL=3);
  - display-mode encodings (RAW=0, DPC=1, BNR=2, CFA=3, AWB=4, CCM=5, GMA=6, ENH=7);
  - gamma type encoding.
- One natural sub-module: isp_auto_seq (dwell counter + index advance, driven by a commit strobe).

Test Plan:
- Reset, pulse vsync → isp_disp_mode=0, gamma_type=0, frame_cnt=1, commit_pulse high exactly 1 cycle after edge.
- Write addr0=5, addr1=2 mid-frame → outputs unchanged and cfg_pending=1 until the next edge; from edge+1, mode=5, gamma=2, cfg_pending=0.
- wr_valid with addr0=3 held in the edge cycle → wr_ready=0 that cycle, accepted next cycle; commit uses the old shadow, and mode=3 appears only after the following edge.
- addr3=2, addr2=1, run 8 frames → modes per committed frame: 0,0,1,1,2,2,3,3; with AUTO_LAST=7 and dwell=1, 7 → 0 wrap verified.
- addr3=0 in auto → mode advances every frame (dwell treated as 1). Write addr2=0 plus addr0=4 → next commit gives mode=4, auto_active=0.
- Reset asserted mid-frame after mode=6 committed → next cycle mode=0, frame_cnt=0; vsync held high 100 cycles yields one commit_pulse.
